mem_stall_ctrl: RTL and testbench

Sequences variable-latency data-memory accesses for the 5-stage pipeline. When the instruction in MEM issues a load or store, this block drives the memory request handshake. It holds every pipeline stage from fetch through MEM until the memory acknowledges, and inserts bubbles into WB meanwhile. It also counts stall cycles and halts the pipeline on a memory timeout. Its stall outputs are ORed with the load-use hazard stalls at the pipeline-register enables; a memory stall takes priority.

---
 rtl/mem_stall_ctrl.sv | 115 +++++++++++
 tb/tb_mem_stall_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: sequences variable-latency data-memory accesses for the
// 5-stage pipeline. It freezes fetch through MEM and bubbles WB until the
// memory acknowledges. It counts memory-stall cycles and halts the pipeline
// for good when an access is never acknowledged.
module mem_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          MemRead_M_i,
  input  logic          MemWrite_M_i,
  input  logic          mem_ack_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic          StallF_o,
  output logic          StallD_o,
  output logic          StallE_o,
  output logic          StallM_o,
  output logic          FlushW_o,
  output logic          mem_timeout_o,
  output logic [CW-1:0] stall_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HALT
  } state_e;

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  localparam logic [CW-1:0] CountMax = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [15:0]   wait_q, wait_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] count_q, count_d;

  logic pending;
  logic req;
  logic stall;

  // Registered state. Reset drops any access in flight and clears the counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic, request/stall decode and the saturating stall counter.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    count_d   = count_q;

    pending = MemRead_M_i | MemWrite_M_i;
    req     = ((state_q == IDLE) && pending) || (state_q == BUSY);
    stall   = (req && !mem_ack_i) || (state_q == HALT);

    case (state_q)
      IDLE: begin
        if (pending && !mem_ack_i) begin
          state_d = BUSY;
          wait_d  = 16'd1;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (wait_q == TimeoutVal) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase

    if (stall && (state_q != HALT) && (count_q != CountMax)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Output drive. Every output is held low while reset is asserted, even the
  // combinational request that follows the pipeline inputs.
  always_comb begin
    mem_req_o     = req & ~reset_i;
    mem_we_o      = MemWrite_M_i & ~reset_i;
    StallF_o      = stall & ~reset_i;
    StallD_o      = stall & ~reset_i;
    StallE_o      = stall & ~reset_i;
    StallM_o      = stall & ~reset_i;
    FlushW_o      = stall & ~reset_i;
    mem_timeout_o = timeout_q & ~reset_i;
    stall_count_o = reset_i ? '0 : count_q;
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl. Instance a uses a short timeout so the
// halt path is reachable. Instance b has a 4-bit counter so that counter
// saturation shows up quickly.
module tb_mem_stall_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd = 1'b0;
  logic wr = 1'b0;
  logic ack = 1'b0;

  logic        reqA, weA, sfA, sdA, seA, smA, fwA, toA;
  logic [31:0] cntA;
  logic        reqB, weB, sfB, sdB, seB, smB, fwB, toB;
  logic [3:0]  cntB;

  int errors = 0;
  int checks = 0;

  mem_stall_ctrl #(.TIMEOUT(4), .CW(32)) dutA (
    .clk_i(clk), .reset_i(reset), .MemRead_M_i(rd), .MemWrite_M_i(wr),
    .mem_ack_i(ack), .mem_req_o(reqA), .mem_we_o(weA),
    .StallF_o(sfA), .StallD_o(sdA), .StallE_o(seA), .StallM_o(smA),
    .FlushW_o(fwA), .mem_timeout_o(toA), .stall_count_o(cntA)
  );

  mem_stall_ctrl #(.TIMEOUT(255), .CW(4)) dutB (
    .clk_i(clk), .reset_i(reset), .MemRead_M_i(rd), .MemWrite_M_i(wr),
    .mem_ack_i(ack), .mem_req_o(reqB), .mem_we_o(weB),
    .StallF_o(sfB), .StallD_o(sdB), .StallE_o(seB), .StallM_o(smB),
    .FlushW_o(fwB), .mem_timeout_o(toB), .stall_count_o(cntB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Start a new cycle: inputs change just after the rising edge, and the
  // outputs are left to settle before any check.
  task automatic applyStimulus(input logic r, input logic w, input logic a);
    @(posedge clk);
    #1;
    rd  = r;
    wr  = w;
    ack = a;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks request, write qualifier and all five stall/flush outputs of instance a.
  task automatic checkA(input string tag, input logic r, input logic w, input logic s);
    checkOutput({tag, ".req"}, {31'd0, reqA}, {31'd0, r});
    checkOutput({tag, ".we"}, {31'd0, weA}, {31'd0, w});
    checkOutput({tag, ".stalls"}, {27'd0, sfA, sdA, seA, smA, fwA}, {27'd0, {5{s}}});
  endtask

  // Holds reset across one edge, then releases it with the request inputs idle.
  task automatic pulseReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd = 1'b0; wr = 1'b0; ack = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state: outputs are low even with a load pending.
    #1;
    rd = 1'b1;
    #1;
    checkA("rst", 1'b0, 1'b0, 1'b0);
    checkOutput("rst.count", cntA, 32'd0);
    checkOutput("rst.timeout", {31'd0, toA}, 32'd0);
    rd = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Zero-wait read.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkA("zw.c1", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkA("zw.after", 1'b0, 1'b0, 1'b0);
    checkOutput("zw.count", cntA, 32'd0);

    // Three-wait read, acknowledged in the 4th cycle.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("w3.c1", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("w3.c2", 1'b1, 1'b0, 1'b1);
    checkOutput("w3.c2.count", cntA, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("w3.c3", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkA("w3.c4", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkA("w3.after", 1'b0, 1'b0, 1'b0);
    checkOutput("w3.count", cntA, 32'd3);

    // Store then load back to back, each acknowledged one cycle late.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkA("b2b.c1", 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkA("b2b.c2", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("b2b.c3", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkA("b2b.c4", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkA("b2b.after", 1'b0, 1'b0, 1'b0);
    checkOutput("b2b.count", cntA, 32'd5);

    // A load and a store together are treated as a write.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkA("rw.c1", 1'b1, 1'b1, 1'b0);

    // Reset during the 2nd BUSY cycle clears everything at once.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("mid.busy2", 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    checkA("mid.rst", 1'b0, 1'b0, 1'b0);
    checkOutput("mid.rst.count", cntA, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("post.c1", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkA("post.c2", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkA("post.after", 1'b0, 1'b0, 1'b0);
    checkOutput("post.count", cntA, 32'd1);

    // An ack in the last BUSY cycle before timeout is still accepted.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkA("late.c5", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkA("late.after", 1'b0, 1'b0, 1'b0);
    checkOutput("late.timeout", {31'd0, toA}, 32'd0);
    checkOutput("late.count", cntA, 32'd4);

    // Timeout: no ack, request high for 5 cycles, then a permanent halt.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("to.c5", 1'b1, 1'b0, 1'b1);
    checkOutput("to.c5.timeout", {31'd0, toA}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("to.halt", 1'b0, 1'b0, 1'b1);
    checkOutput("to.halt.timeout", {31'd0, toA}, 32'd1);
    checkOutput("to.halt.count", cntA, 32'd5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkA("to.ack", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkA("to.later", 1'b0, 1'b0, 1'b1);
    checkOutput("to.later.timeout", {31'd0, toA}, 32'd1);
    checkOutput("to.later.count", cntA, 32'd5);

    // Saturation on the 4-bit counter: 20 stalled cycles hold at 15.
    pulseReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 14) checkOutput("sat.c15.count", {28'd0, cntB}, 32'd14);
    end
    checkOutput("sat.req", {31'd0, reqB}, 32'd1);
    checkOutput("sat.count", {28'd0, cntB}, 32'd15);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("sat.ack.stall", {31'd0, sfB}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sat.hold", {28'd0, cntB}, 32'd15);
    checkOutput("sat.timeout", {31'd0, toB}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
